if_stage: RTL and testbench

- Instruction-fetch stage: owns the PC, drives the instruction-memory/cache read handshake, and holds the IF/ID pipeline register.
- Feeds ID_stage directly with opcode, funct3, funct7, rs1, rs2, rd, immediates and PC.
- Absorbs taken-branch redirects from EX and inserts NOP bubbles when no instruction is available.

---
 rtl/branchmux.sv | 12 +
 rtl/if_stage_pkg.sv | 27 ++
 rtl/rv32i_types.sv | 28 ++
 rtl/if_stage_ifid_reg.sv | 70 +++++++
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/branchmux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branchmux : PC-source select encoding shared by EX and IF          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package branchmux;
  typedef enum logic {
    pcplus4  = 1'b0,
    br_taken = 1'b1
  } branchmux_sel_t;
endpackage
`default_nettype wire

// File: rtl/if_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage_pkg : RV32I immediate decoders used by the IF/ID register |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package if_stage_pkg;
  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{21{ir[31]}}, ir[30:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{21{ir[31]}}, ir[30:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction
endpackage
`default_nettype wire

// File: rtl/rv32i_types.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_types : opcode encodings, fetch FSM states, bubble encoding  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage
`default_nettype wire

// File: rtl/if_stage_ifid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifid_reg : IF/ID pipeline register plus field/immediate decode     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ifid_reg
  import rv32i_types::rv32i_opcode;
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output rv32i_opcode o_opcode,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [31:0] o_i_imm,
  output logic [31:0] o_s_imm,
  output logic [31:0] o_b_imm,
  output logic [31:0] o_u_imm,
  output logic [31:0] o_j_imm
);
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  // A bubble leaves the PC field untouched; only the word and valid change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      if (i_bubble) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end else begin
        r_valid <= 1'b1;
        r_pc    <= i_pc;
        r_instr <= i_instr;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_pc     = r_pc;
  assign o_instr  = r_instr;
  assign o_opcode = rv32i_opcode'(r_instr[6:0]);
  assign o_funct3 = r_instr[14:12];
  assign o_funct7 = r_instr[31:25];
  assign o_rs1    = r_instr[19:15];
  assign o_rs2    = r_instr[24:20];
  assign o_rd     = r_instr[11:7];
  assign o_i_imm  = imm_i(r_instr);
  assign o_s_imm  = imm_s(r_instr);
  assign o_b_imm  = imm_b(r_instr);
  assign o_u_imm  = imm_u(r_instr);
  assign o_j_imm  = imm_j(r_instr);
endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage : PC owner, instruction-memory handshake and IF/ID stage  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module if_stage
  import branchmux::branchmux_sel_t, branchmux::br_taken;
  import rv32i_types::rv32i_opcode, rv32i_types::fetch_state_t;
  import rv32i_types::REQ, rv32i_types::HOLD, rv32i_types::FLUSH;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pipeline_en,
  input  branchmux_sel_t branchmux_sel,
  input  logic [31:0]    br_target,
  output logic           inst_read,
  output logic [31:0]    inst_addr,
  input  logic           inst_resp,
  input  logic [31:0]    inst_rdata,
  output logic           valid_id,
  output logic [31:0]    pc_id,
  output logic [31:0]    instr_id,
  output rv32i_opcode    opcode_id,
  output logic [2:0]     funct3_id,
  output logic [6:0]     funct7_id,
  output logic [4:0]     rs1_id,
  output logic [4:0]     rs2_id,
  output logic [4:0]     rd_id,
  output logic [31:0]    i_imm,
  output logic [31:0]    s_imm,
  output logic [31:0]    b_imm,
  output logic [31:0]    u_imm,
  output logic [31:0]    j_imm
);
  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, w_next_pc;
  logic [31:0]  r_hold, w_next_hold;
  logic [31:0]  r_redir_pc, w_next_redir_pc;
  logic         w_redirect;
  logic         w_deliver;
  logic [31:0]  w_deliver_instr;
  logic [31:0]  w_pc_plus4;

  assign w_redirect = (branchmux_sel == br_taken) && pipeline_en;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_hold     <= '0;
      r_redir_pc <= '0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_hold     <= w_next_hold;
      r_redir_pc <= w_next_redir_pc;
    end
  end

  // The request address is always r_pc; in FLUSH r_pc still holds the
  // abandoned address so it stays stable until memory answers.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_next_hold     = r_hold;
    w_next_redir_pc = r_redir_pc;
    inst_read       = 1'b0;
    inst_addr       = r_pc;
    w_deliver       = 1'b0;
    w_deliver_instr = inst_rdata;
    case (r_state)
      REQ: begin
        inst_read = 1'b1;
        if (w_redirect) begin
          if (inst_resp) begin
            w_next_pc = br_target;
          end else begin
            w_next_redir_pc = br_target;
            w_next_state    = FLUSH;
          end
        end else if (inst_resp) begin
          if (pipeline_en) begin
            w_deliver = 1'b1;
            w_next_pc = w_pc_plus4;
          end else begin
            w_next_hold  = inst_rdata;
            w_next_state = HOLD;
          end
        end
      end
      HOLD: begin
        w_deliver_instr = r_hold;
        if (w_redirect) begin
          w_next_hold  = '0;
          w_next_pc    = br_target;
          w_next_state = REQ;
        end else if (pipeline_en) begin
          w_deliver    = 1'b1;
          w_next_pc    = w_pc_plus4;
          w_next_state = REQ;
        end
      end
      FLUSH: begin
        inst_read = 1'b1;
        if (w_redirect) w_next_redir_pc = br_target;
        if (inst_resp) begin
          w_next_pc    = w_redirect ? br_target : r_redir_pc;
          w_next_state = REQ;
        end
      end
      default: w_next_state = REQ;
    endcase
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (pipeline_en),
    .i_bubble (!w_deliver),
    .i_instr  (w_deliver_instr),
    .i_pc     (r_pc),
    .o_valid  (valid_id),
    .o_pc     (pc_id),
    .o_instr  (instr_id),
    .o_opcode (opcode_id),
    .o_funct3 (funct3_id),
    .o_funct7 (funct7_id),
    .o_rs1    (rs1_id),
    .o_rs2    (rs2_id),
    .o_rd     (rd_id),
    .o_i_imm  (i_imm),
    .o_s_imm  (s_imm),
    .o_b_imm  (b_imm),
    .o_u_imm  (u_imm),
    .o_j_imm  (j_imm)
  );
endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_if_stage : directed self-checking bench for if_stage            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_if_stage;
  import branchmux::*;
  import rv32i_types::*;

  logic           clk;
  logic           rst;
  logic           pipeline_en;
  branchmux_sel_t branchmux_sel;
  logic [31:0]    br_target;
  logic           inst_read;
  logic [31:0]    inst_addr;
  logic           inst_resp;
  logic [31:0]    inst_rdata;
  logic           valid_id;
  logic [31:0]    pc_id;
  logic [31:0]    instr_id;
  rv32i_opcode    opcode_id;
  logic [2:0]     funct3_id;
  logic [6:0]     funct7_id;
  logic [4:0]     rs1_id;
  logic [4:0]     rs2_id;
  logic [4:0]     rd_id;
  logic [31:0]    i_imm;
  logic [31:0]    s_imm;
  logic [31:0]    b_imm;
  logic [31:0]    u_imm;
  logic [31:0]    j_imm;

  int n_chk  = 0;
  int n_pass = 0;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pipeline_en   (pipeline_en),
    .branchmux_sel (branchmux_sel),
    .br_target     (br_target),
    .inst_read     (inst_read),
    .inst_addr     (inst_addr),
    .inst_resp     (inst_resp),
    .inst_rdata    (inst_rdata),
    .valid_id      (valid_id),
    .pc_id         (pc_id),
    .instr_id      (instr_id),
    .opcode_id     (opcode_id),
    .funct3_id     (funct3_id),
    .funct7_id     (funct7_id),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rd_id         (rd_id),
    .i_imm         (i_imm),
    .s_imm         (s_imm),
    .b_imm         (b_imm),
    .u_imm         (u_imm),
    .j_imm         (j_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_chk++; if (valid_id !== 1'b0) $display("FAIL rst_valid got %0b exp 0", valid_id); else n_pass++;
    n_chk++; if (pc_id !== 32'h0) $display("FAIL rst_pc_id got %h exp 00000000", pc_id); else n_pass++;
    n_chk++; if (instr_id !== 32'h13) $display("FAIL rst_instr got %h exp 00000013", instr_id); else n_pass++;
    n_chk++; if (opcode_id !== op_imm) $display("FAIL rst_opcode got %h exp 13", opcode_id); else n_pass++;
    n_chk++; if ({rd_id, rs1_id, rs2_id} !== 15'h0) $display("FAIL rst_regs got %h exp 0", {rd_id, rs1_id, rs2_id}); else n_pass++;
    n_chk++; if (inst_addr !== 32'h60 || inst_read !== 1'b1) $display("FAIL rst_req got addr %h rd %0b exp 00000060 1", inst_addr, inst_read); else n_pass++;
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] words [5];
    words = '{32'h00A0_0093, 32'h1234_52B7, 32'hFE51_2E23, 32'h0080_006F, 32'hFE00_0EE3};
    rst = 1'b1;
    pipeline_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (inst_addr !== 32'h60 + 32'(4 * i) || inst_read !== 1'b1) $display("FAIL seq_addr%0d got %h exp %h", i, inst_addr, 32'h60 + 32'(4 * i)); else n_pass++;
      inst_resp = 1'b1;
      inst_rdata = words[i];
      step();
      inst_resp = 1'b0;
      n_chk++; if (pc_id !== 32'h60 + 32'(4 * i) || valid_id !== 1'b1 || instr_id !== words[i]) $display("FAIL seq_ifid%0d got pc %h v %0b ir %h exp pc %h v 1 ir %h", i, pc_id, valid_id, instr_id, 32'h60 + 32'(4 * i), words[i]); else n_pass++;
      case (i)
        0: begin
          n_chk++; if (rd_id !== 5'd1 || i_imm !== 32'd10 || opcode_id !== op_imm) $display("FAIL seq_addi got rd %0d imm %h exp rd 1 imm 0000000a", rd_id, i_imm); else n_pass++;
        end
        1: begin
          n_chk++; if (rd_id !== 5'd5 || u_imm !== 32'h1234_5000 || opcode_id !== op_lui) $display("FAIL seq_lui got rd %0d imm %h exp rd 5 imm 12345000", rd_id, u_imm); else n_pass++;
        end
        2: begin
          n_chk++; if (s_imm !== 32'hFFFF_FFFC || rs1_id !== 5'd2 || rs2_id !== 5'd5 || funct3_id !== 3'd2) $display("FAIL seq_sw got imm %h rs1 %0d rs2 %0d f3 %0d exp fffffffc 2 5 2", s_imm, rs1_id, rs2_id, funct3_id); else n_pass++;
        end
        3: begin
          n_chk++; if (j_imm !== 32'd8 || opcode_id !== op_jal) $display("FAIL seq_jal got imm %h exp 00000008", j_imm); else n_pass++;
        end
        default: begin
          n_chk++; if (b_imm !== 32'hFFFF_FFFC || funct7_id !== 7'h7F) $display("FAIL seq_beq got imm %h f7 %h exp fffffffc 7f", b_imm, funct7_id); else n_pass++;
        end
      endcase
    end
  endtask

  task automatic test_hold();
    n_chk++; if (inst_addr !== 32'h74) $display("FAIL hold_pre_addr got %h exp 00000074", inst_addr); else n_pass++;
    pipeline_en = 1'b0;
    inst_resp = 1'b1;
    inst_rdata = 32'h0050_0193;
    step();
    inst_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (inst_read !== 1'b0) $display("FAIL hold_read%0d got %0b exp 0", k, inst_read); else n_pass++;
      n_chk++; if (pc_id !== 32'h70 || instr_id !== 32'hFE00_0EE3 || valid_id !== 1'b1) $display("FAIL hold_frozen%0d got pc %h ir %h v %0b exp 00000070 fe000ee3 1", k, pc_id, instr_id, valid_id); else n_pass++;
      if (k == 0) step();
    end
    pipeline_en = 1'b1;
    step();
    n_chk++; if (pc_id !== 32'h74 || instr_id !== 32'h0050_0193 || valid_id !== 1'b1 || i_imm !== 32'd5) $display("FAIL hold_release got pc %h ir %h v %0b exp 00000074 00500193 1", pc_id, instr_id, valid_id); else n_pass++;
    n_chk++; if (inst_addr !== 32'h78 || inst_read !== 1'b1) $display("FAIL hold_next_addr got %h rd %0b exp 00000078 1", inst_addr, inst_read); else n_pass++;
  endtask

  task automatic test_redirect_with_resp();
    branchmux_sel = br_taken;
    br_target = 32'h200;
    inst_resp = 1'b1;
    inst_rdata = 32'h0070_0213;
    step();
    branchmux_sel = pcplus4;
    inst_resp = 1'b0;
    n_chk++; if (valid_id !== 1'b0 || instr_id !== 32'h13) $display("FAIL redir_bubble got v %0b ir %h exp 0 00000013", valid_id, instr_id); else n_pass++;
    n_chk++; if (inst_addr !== 32'h200) $display("FAIL redir_addr got %h exp 00000200", inst_addr); else n_pass++;
  endtask

  task automatic test_flush();
    branchmux_sel = br_taken;
    br_target = 32'h80;
    inst_resp = 1'b1;
    inst_rdata = 32'h0060_0193;
    step();
    inst_resp = 1'b0;
    n_chk++; if (inst_addr !== 32'h80) $display("FAIL flush_setup got %h exp 00000080", inst_addr); else n_pass++;
    br_target = 32'h300;
    step();
    branchmux_sel = pcplus4;
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (inst_addr !== 32'h80 || inst_read !== 1'b1 || valid_id !== 1'b0) $display("FAIL flush_wait%0d got addr %h rd %0b v %0b exp 00000080 1 0", k, inst_addr, inst_read, valid_id); else n_pass++;
      if (k == 0) step();
    end
    inst_resp = 1'b1;
    inst_rdata = 32'h0080_0293;
    step();
    inst_resp = 1'b0;
    n_chk++; if (inst_addr !== 32'h300 || valid_id !== 1'b0 || instr_id !== 32'h13) $display("FAIL flush_done got addr %h v %0b ir %h exp 00000300 0 00000013", inst_addr, valid_id, instr_id); else n_pass++;
    step();
    n_chk++; if (inst_addr !== 32'h300 || valid_id !== 1'b0) $display("FAIL flush_idle got addr %h v %0b exp 00000300 0", inst_addr, valid_id); else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    inst_resp = 1'b1;
    inst_rdata = 32'h00A0_0093;
    step();
    inst_resp = 1'b0;
    branchmux_sel = br_taken;
    br_target = 32'h400;
    step();
    branchmux_sel = pcplus4;
    n_chk++; if (inst_addr !== 32'h304 || pc_id !== 32'h300) $display("FAIL rflush_pre got addr %h pc %h exp 00000304 00000300", inst_addr, pc_id); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (inst_addr !== 32'h60 || inst_read !== 1'b1 || valid_id !== 1'b0 || pc_id !== 32'h0 || instr_id !== 32'h13) $display("FAIL rflush_async got addr %h rd %0b v %0b pc %h ir %h exp 00000060 1 0 00000000 00000013", inst_addr, inst_read, valid_id, pc_id, instr_id); else n_pass++;
    step();
    rst = 1'b1;
    n_chk++; if (inst_addr !== 32'h60 || inst_read !== 1'b1) $display("FAIL rflush_release got addr %h rd %0b exp 00000060 1", inst_addr, inst_read); else n_pass++;
    inst_resp = 1'b1;
    inst_rdata = 32'h1234_52B7;
    step();
    inst_resp = 1'b0;
    n_chk++; if (pc_id !== 32'h60 || valid_id !== 1'b1 || inst_addr !== 32'h64) $display("FAIL rflush_fetch got pc %h v %0b addr %h exp 00000060 1 00000064", pc_id, valid_id, inst_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    branchmux_sel = br_taken;
    br_target = 32'hFFFF_FFFC;
    inst_resp = 1'b1;
    step();
    branchmux_sel = pcplus4;
    inst_resp = 1'b0;
    n_chk++; if (inst_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_pre got %h exp fffffffc", inst_addr); else n_pass++;
    inst_resp = 1'b1;
    inst_rdata = 32'h00A0_0093;
    step();
    inst_resp = 1'b0;
    n_chk++; if (pc_id !== 32'hFFFF_FFFC || valid_id !== 1'b1) $display("FAIL wrap_ifid got pc %h v %0b exp fffffffc 1", pc_id, valid_id); else n_pass++;
    n_chk++; if (inst_addr !== 32'h0) $display("FAIL wrap_addr got %h exp 00000000", inst_addr); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    pipeline_en = 1'b0;
    branchmux_sel = pcplus4;
    br_target = '0;
    inst_resp = 1'b0;
    inst_rdata = '0;
    test_reset();
    test_sequential_fetch();
    test_hold();
    test_redirect_with_resp();
    test_flush();
    test_reset_mid_flush();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
